sync_gen: RTL

SYNC_GEN -- requirements
Module: sync_gen

---
 rtl/sync_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sync_gen.sv
// sync_gen: raster timing generator.
//   Produces line/frame strobes and active-pixel coordinates from a free-running
//   horizontal counter (h_cnt) and a line counter (v_cnt). Frames are generated
//   while en is high; en is only honoured at the last clock of a frame, so a
//   frame once started always completes (unless rst aborts it).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           run request
//   horizantal   high during the H_ACTIVE clocks of every line
//   vertical     high during the V_ACTIVE lines of a frame
//   de           horizantal & vertical
//   pixel_h      active column (h_cnt >> 3), 0 outside active clocks
//   pixel_v      active line (v_cnt), 0 outside active lines
//   line_start   one-clock pulse on the first clock of each line
//   frame_start  one-clock pulse on the first clock of each frame
module sync_gen #(
    parameter int H_ACTIVE = 2560,
    parameter int H_BLANK  = 256,
    parameter int V_ACTIVE = 288,
    parameter int V_BLANK  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       horizantal,
    output logic       vertical,
    output logic       de,
    output logic [8:0] pixel_h,
    output logic [8:0] pixel_v,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    generate
        if (H_ACTIVE == 0 || H_BLANK == 0 || V_ACTIVE == 0 || V_BLANK == 0 ||
            H_TOTAL > 4096 || V_TOTAL > 512 || (H_ACTIVE / 8) > 512) begin : g_bad_params
            $error("sync_gen: illegal timing parameters");
        end
    endgenerate

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST = 9'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [8:0]  V_ACT  = 9'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] h_cnt;
    logic [11:0] h_nxt;
    logic [8:0]  v_cnt;
    logic [8:0]  v_nxt;
    logic        run_nxt;
    logic        h_on_nxt;
    logic        v_on_nxt;

    // Next-cycle counter/state values. Outputs are registered from these, so
    // every output lines up with the h_cnt/v_cnt value it describes.
    always_comb begin
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        run_nxt = (state != IDLE);
        if (state == IDLE) begin
            h_nxt   = '0;
            v_nxt   = '0;
            run_nxt = en;
        end else if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                // Last clock of the frame: the only point where en is looked at.
                v_nxt   = '0;
                run_nxt = en;
            end else begin
                v_nxt = v_cnt + 9'd1;
            end
        end else begin
            h_nxt = h_cnt + 12'd1;
        end

        if (!run_nxt) begin
            state_nxt = IDLE;
        end else if (h_nxt < H_ACT) begin
            state_nxt = ACTIVE;
        end else begin
            state_nxt = HBLANK;
        end

        h_on_nxt = (state_nxt == ACTIVE);
        // Vertical blank is just a line-range flag; it changes only with h_nxt == 0,
        // so it is already low when horizantal rises on the first blank line.
        v_on_nxt = run_nxt && (v_nxt < V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            horizantal  <= 1'b0;
            vertical    <= 1'b0;
            de          <= 1'b0;
            pixel_h     <= '0;
            pixel_v     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            horizantal  <= h_on_nxt;
            vertical    <= v_on_nxt;
            de          <= h_on_nxt && v_on_nxt;
            pixel_h     <= h_on_nxt ? h_nxt[11:3] : 9'd0;
            pixel_v     <= v_on_nxt ? v_nxt : 9'd0;
            line_start  <= run_nxt && (h_nxt == 12'd0);
            frame_start <= run_nxt && (h_nxt == 12'd0) && (v_nxt == 9'd0);
        end
    end

endmodule
